rx_cmd_buffer: RTL and testbench
================================

// Module: rx_cmd_buffer
// PURPOSE
//  Reader side of the UART receive path. Captures each byte strobed out of async_receiver
//  into a circular FIFO and hands bytes one at a time to the command decoder (decoding)
//  over a valid/take handshake. This keeps host command bursts from being lost while
//  motors or scans are busy. Also flags overflow and supports a host-issued flush byte.
// PARAMETERS
//  DEPTH      16    FIFO entries; must be a power of two, 2..256
//  ADDR_W     4     log2(DEPTH)
//  FLUSH_BYTE 8'hFF incoming byte that empties the FIFO and is itself discarded
// PORTS
//  clk           in   1      50 MHz system clock (CLOCK_50)
//  reset_n       in   1      synchronous, active-low reset
//  rx_ready      in   1      one-cycle strobe from async_receiver (RxD_data_ready)
//  rx_data       in   8      received byte; valid only in the rx_ready cycle
//  cmd_take      in   1      decoder consumes the byte on cmd_data this cycle
//  ovf_clear     in   1      clears the sticky overflow flag
//  cmd_valid     out  1      cmd_data holds the oldest unconsumed byte
//  cmd_data      out  8      head-of-FIFO byte, registered
//  count         out  ADDR_W+1  number of bytes held, 0..DEPTH
//  full          out  1      count == DEPTH
//  overflow      out  1      sticky: a byte was dropped because the FIFO was full
//  flushed       out  1      one-cycle pulse when FLUSH_BYTE is accepted
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): wr_ptr=rd_ptr=0, count=0, cmd_valid=0,
//   cmd_data=8'h00, full=0, overflow=0, flushed=0. Reset wins over all other inputs.
//   Reset mid-transfer discards all buffered bytes.
//  Pointers are ADDR_W bits wide and wrap modulo DEPTH. count is tracked separately,
//   so full and empty are never ambiguous.
//  Write: on rx_ready=1 with rx_data!=FLUSH_BYTE:
//   - if count<DEPTH, or a take happens in the same cycle: mem[wr_ptr]<=rx_data,
//     then wr_ptr+1.
//   - else the byte is dropped and overflow<=1.
//  Read: cmd_data/cmd_valid follow a show-ahead head. cmd_valid=1 iff count>0.
//   cmd_take is honoured only when cmd_valid=1 and is ignored otherwise.
//   On a take, rd_ptr+1; the next byte appears on cmd_data the following cycle.
//   Latency from rx_ready into an empty FIFO to cmd_valid=1 is 1 cycle; the
//   cmd_data value matches in that same cycle.
//  Simultaneous write+take: count is unchanged. When full, the write succeeds because the
//   take frees a slot in the same cycle, and overflow is not set.
//  Simultaneous write+take with count==1: the new byte becomes the head on the next
//   cycle and cmd_valid stays 1.
//  Flush: rx_ready=1 with rx_data==FLUSH_BYTE sets wr_ptr=rd_ptr=0, count=0,
//   cmd_valid=0 on the next cycle, and flushed=1 for exactly that one cycle. A cmd_take in
//   the flush cycle is discarded. overflow is not changed by a flush.
//  overflow clears only on ovf_clear=1 or reset. If ovf_clear and a new drop coincide,
//   the drop wins (overflow stays 1).
//  States: EMPTY (count=0), PART (0<count<DEPTH), FULL (count=DEPTH).
//   EMPTY->PART on a write; PART->EMPTY on a take with count==1 and no write;
//   PART->FULL on a write with count==DEPTH-1 and no take; FULL->PART on a take with
//   no write. Any state goes to EMPTY on a flush or on reset.
//  rx_ready is assumed to be a clean 1-cycle strobe. Back-to-back strobes are each
//   accepted.
// TESTING
//  1. Reset, then rx 8'h21 -> next cycle cmd_valid=1, cmd_data=8'h21, count=1; take ->
//     next cycle cmd_valid=0, count=0.
//  2. Write 16 bytes 8'h00..8'h0F with no take -> full=1, count=16; 17th byte 8'h10 ->
//     dropped, overflow=1; reading all 16 yields 8'h00..8'h0F in order.
//  3. FIFO full and rx 8'h55 coincides with a take -> overflow stays 0, count stays 16,
//     and 8'h55 is read last.
//  4. Write 8'h01 and 8'h02, then rx 8'hFF -> flushed pulses once, count=0, cmd_valid=0;
//     no 8'hFF is ever presented on cmd_data.
//  5. Wrap-around: 40 bytes streamed with one take every 3 cycles -> output sequence equals
//     input sequence and count never exceeds 16.
//  6. Set overflow, then assert ovf_clear in the same cycle as another drop -> overflow stays
//     1; ovf_clear alone -> overflow=0. reset_n=0 mid-stream -> all outputs return to reset
//     values.

Source files
------------

// File: rtl/rx_cmd_buffer.sv
// rx_cmd_buffer: circular FIFO between the UART receiver and the command decoder, with overflow flag and flush byte
module rx_cmd_buffer #(
    parameter int DEPTH = 16,
    parameter int ADDR_W = 4,
    parameter logic [7:0] FLUSH_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    input  logic              cmd_take,
    input  logic              ovf_clear,
    output logic              cmd_valid,
    output logic [7:0]        cmd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic              flushed
);
    typedef enum logic [1:0] {EMPTY, PART, FULL} state_t;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    state_t state, state_n;
    logic [7:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_next;
    logic [ADDR_W:0] remain, count_n;
    logic flush, take, wr, drop;
    assign cmd_valid = state != EMPTY;
    assign full = state == FULL;
    // Decode this cycle's flush, take, write and drop, and the resulting occupancy
    always_comb begin
        flush = rx_ready && rx_data == FLUSH_BYTE;
        take = cmd_take && cmd_valid && !flush;
        wr = rx_ready && !flush && (!full || take);
        drop = rx_ready && !flush && full && !take;
        rd_next = rd_ptr + ADDR_W'(take);
        remain = count - (ADDR_W+1)'(take);
        count_n = remain + (ADDR_W+1)'(wr);
        state_n = count_n == '0 ? EMPTY : count_n == FULL_CNT ? FULL : PART;
    end
    // Storage array; a write into the slot freed by a same-cycle take is legal
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= rx_data;
    end
    // Pointers, occupancy state, show-ahead head register and status flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            state <= EMPTY;
            cmd_data <= 8'h00;
            overflow <= 1'b0;
            flushed <= 1'b0;
        end else begin
            overflow <= drop || (overflow && !ovf_clear);
            flushed <= flush;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
                state <= EMPTY;
            end else begin
                wr_ptr <= wr_ptr + ADDR_W'(wr);
                rd_ptr <= rd_next;
                count <= count_n;
                state <= state_n;
                if (count_n != '0) cmd_data <= remain == '0 ? rx_data : mem[rd_next];
            end
        end
    end
endmodule

// File: tb/tb_rx_cmd_buffer.sv
// tb_rx_cmd_buffer: directed self-checking bench for rx_cmd_buffer
module tb_rx_cmd_buffer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic cmd_take = 1'b0;
    logic ovf_clear = 1'b0;
    logic cmd_valid;
    logic [7:0] cmd_data;
    logic [4:0] count;
    logic full, overflow, flushed;
    int errors = 0;
    int checks = 0;

    rx_cmd_buffer dut (
        .clk(clk), .reset_n(reset_n), .rx_ready(rx_ready), .rx_data(rx_data),
        .cmd_take(cmd_take), .ovf_clear(ovf_clear), .cmd_valid(cmd_valid),
        .cmd_data(cmd_data), .count(count), .full(full), .overflow(overflow),
        .flushed(flushed)
    );

    always #10 clk = ~clk;

    // One clock with the given inputs held across the edge; outputs sampled 1ns after it
    task automatic cyc(input logic r, input logic [7:0] d, input logic t, input logic oc);
        rx_ready = r;
        rx_data = d;
        cmd_take = t;
        ovf_clear = oc;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        rx_data = 8'h00;
        cmd_take = 1'b0;
        ovf_clear = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        cyc(1'b1, 8'h33, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({cmd_valid, cmd_data, count, full, overflow, flushed} !== 17'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", {cmd_valid, cmd_data, count, full, overflow, flushed}, 17'h0);
        end
        reset_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_single;
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        checks++;
        if ({cmd_valid, cmd_data, count} !== {1'b1, 8'h21, 5'd1}) begin
            errors++;
            $display("FAIL single_write: got valid=%b data=%h count=%0d expected valid=1 data=21 count=1", cmd_valid, cmd_data, count);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({cmd_valid, count} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL single_take: got valid=%b count=%0d expected valid=0 count=0", cmd_valid, count);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({cmd_valid, count} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL take_when_empty: got valid=%b count=%0d expected valid=0 count=0", cmd_valid, count);
        end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        checks++;
        if ({full, count, overflow} !== {1'b1, 5'd16, 1'b0}) begin
            errors++;
            $display("FAIL fill_full: got full=%b count=%0d ovf=%b expected full=1 count=16 ovf=0", full, count, overflow);
        end
        cyc(1'b1, 8'h10, 1'b0, 1'b0);
        checks++;
        if ({full, count, overflow} !== {1'b1, 5'd16, 1'b1}) begin
            errors++;
            $display("FAIL fill_drop: got full=%b count=%0d ovf=%b expected full=1 count=16 ovf=1", full, count, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({cmd_valid, cmd_data} !== {1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL fill_read[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, cmd_valid, cmd_data, 8'(i));
            end
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if ({cmd_valid, count, full} !== {1'b0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL fill_drained: got valid=%b count=%0d full=%b expected 0 0 0", cmd_valid, count, full);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_ovf_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_full_take;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if ({overflow, count, full, cmd_data} !== {1'b0, 5'd16, 1'b1, 8'h31}) begin
            errors++;
            $display("FAIL full_take: got ovf=%b count=%0d full=%b data=%h expected ovf=0 count=16 full=1 data=31", overflow, count, full, cmd_data);
        end
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] exp;
            exp = i == 16 ? 8'h55 : 8'h30 + 8'(i);
            checks++;
            if ({cmd_valid, cmd_data} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL full_take_read[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, cmd_valid, cmd_data, exp);
            end
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL full_take_empty: got count=%0d expected 0", count);
        end
    endtask

    task automatic test_flush;
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        checks++;
        if ({count, cmd_data} !== {5'd2, 8'h01}) begin
            errors++;
            $display("FAIL flush_pre: got count=%0d data=%h expected count=2 data=01", count, cmd_data);
        end
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        checks++;
        if ({flushed, count, cmd_valid} !== {1'b1, 5'd0, 1'b0} || cmd_data === 8'hFF) begin
            errors++;
            $display("FAIL flush_pulse: got flushed=%b count=%0d valid=%b data=%h expected flushed=1 count=0 valid=0 data!=ff", flushed, count, cmd_valid, cmd_data);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({flushed, count, cmd_valid} !== {1'b0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush_once: got flushed=%b count=%0d valid=%b expected 0 0 0", flushed, count, cmd_valid);
        end
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h78, 1'b0, 1'b0);
        checks++;
        if ({cmd_valid, cmd_data, count} !== {1'b1, 8'h77, 5'd2}) begin
            errors++;
            $display("FAIL flush_after: got valid=%b data=%h count=%0d expected valid=1 data=77 count=2", cmd_valid, cmd_data, count);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h79, 1'b1, 1'b0);
        checks++;
        if ({cmd_valid, cmd_data, count} !== {1'b1, 8'h79, 5'd1}) begin
            errors++;
            $display("FAIL write_take_one: got valid=%b data=%h count=%0d expected valid=1 data=79 count=1", cmd_valid, cmd_data, count);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        logic [7:0] q[$];
        int sent = 0;
        int k = 0;
        for (k = 0; k < 400 && !(sent == 40 && q.size() == 0); k++) begin
            logic r, t;
            r = sent < 40 && (k < 10 || k % 3 == 0);
            t = k % 3 == 2 && q.size() > 0;
            if (t) begin
                checks++;
                if ({cmd_valid, cmd_data} !== {1'b1, q[0]}) begin
                    errors++;
                    $display("FAIL wrap_data[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, cmd_valid, cmd_data, q[0]);
                end
            end
            cyc(r, 8'h80 + 8'(sent), t, 1'b0);
            if (t) void'(q.pop_front());
            if (r) begin
                q.push_back(8'h80 + 8'(sent));
                sent++;
            end
            checks++;
            if (count !== 5'(q.size()) || count > 5'd16) begin
                errors++;
                $display("FAIL wrap_count[%0d]: got %0d expected %0d", k, count, q.size());
            end
        end
        checks++;
        if (sent != 40 || q.size() != 0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: got sent=%0d left=%0d valid=%b expected 40 0 0", sent, q.size(), cmd_valid);
        end
    endtask

    task automatic test_ovf_reset;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", overflow);
        end
        cyc(1'b1, 8'h12, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear_vs_drop: got %b expected 1", overflow);
        end
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++;
        if ({overflow, count, flushed} !== {1'b1, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_flush: got ovf=%b count=%0d flushed=%b expected ovf=1 count=0 flushed=1", overflow, count, flushed);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        checks++;
        if ({overflow, full} !== 2'b11) begin
            errors++;
            $display("FAIL midstream_pre: got ovf=%b full=%b expected 1 1", overflow, full);
        end
        reset_n = 1'b0;
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        checks++;
        if ({cmd_valid, cmd_data, count, full, overflow, flushed} !== 17'h0) begin
            errors++;
            $display("FAIL midstream_reset: got %h expected %h", {cmd_valid, cmd_data, count, full, overflow, flushed}, 17'h0);
        end
        reset_n = 1'b1;
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        checks++;
        if ({cmd_valid, cmd_data, count} !== {1'b1, 8'h5A, 5'd1}) begin
            errors++;
            $display("FAIL post_reset_write: got valid=%b data=%h count=%0d expected valid=1 data=5a count=1", cmd_valid, cmd_data, count);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fill;
        test_full_take;
        test_flush;
        test_wrap;
        test_ovf_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
